// File: rtl/minesweeper_pkg.sv
// Shared minesweeper definitions: board defaults, generator FSM states, LFSR seed.
// Latency: n/a (types, constants and one helper function only).
// Backpressure: n/a.
package minesweeper_pkg;

  localparam int          GRID_W_DEF    = 8;
  localparam int          GRID_H_DEF    = 8;
  localparam int          CELLS_DEF     = GRID_W_DEF * GRID_H_DEF;
  localparam int          IDX_W_DEF     = $clog2(CELLS_DEF);
  localparam int          NUM_MINES_DEF = 10;
  localparam logic [15:0] LFSR_SEED_DEF = 16'hACE1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CLEAR = 2'd1,
    ST_PICK  = 2'd2,
    ST_DONE  = 2'd3
  } gen_state_t;

  // An all-zero Fibonacci LFSR locks up, so a zero seed falls back to the default.
  function automatic logic [15:0] fix_seed(input logic [15:0] s);
    return (s == 16'h0000) ? LFSR_SEED_DEF : s;
  endfunction

endpackage

// File: rtl/lfsr16.sv
// Free-running 16-bit Fibonacci LFSR (taps 16,14,13,11), low OUT_W bits exposed as q.
// Latency: q reflects the register state; advances every non-reset clock.
// Backpressure: none, never stalls.
// Ports: clk, reset_in (sync, active-high, loads seed), seed[15:0], q[OUT_W-1:0].
module lfsr16
  import minesweeper_pkg::*;
#(
  parameter int OUT_W = 16
) (
  input  logic             clk,
  input  logic             reset_in,
  input  logic [15:0]      seed,
  output logic [OUT_W-1:0] q
);

  logic [15:0] state;
  logic        fb;

  assign fb = state[15] ^ state[13] ^ state[12] ^ state[10];
  assign q  = state[OUT_W-1:0];

  always_ff @(posedge clk) begin
    if (reset_in) begin
      state <= fix_seed(seed);
    end else begin
      state <= {state[14:0], fb};
    end
  end

endmodule

// File: rtl/mine_field_generator.sv
// Places NUM_MINES distinct mines via LFSR on a start pulse; serves mine bit + neighbour count.
// Latency: start->gen_done >= NUM_MINES+2 cycles (rejected candidates add cycles); read port 1 cycle.
// Backpressure: none; starts outside IDLE are dropped, busy flags the generation window.
// Ports: clk, reset_in, enable_mine_generation, busy, gen_done, mine_map, rd_x, rd_y, rd_mine, rd_adj.
module mine_field_generator
  import minesweeper_pkg::*;
#(
  parameter int          GRID_W    = GRID_W_DEF,
  parameter int          GRID_H    = GRID_H_DEF,
  parameter int          NUM_MINES = NUM_MINES_DEF,
  parameter logic [15:0] SEED      = LFSR_SEED_DEF
) (
  input  logic                        clk,
  input  logic                        reset_in,
  input  logic                        enable_mine_generation,
  output logic                        busy,
  output logic                        gen_done,
  output logic [GRID_W*GRID_H-1:0]    mine_map,
  input  logic [$clog2(GRID_W)-1:0]   rd_x,
  input  logic [$clog2(GRID_H)-1:0]   rd_y,
  output logic                        rd_mine,
  output logic [3:0]                  rd_adj
);

  localparam int CELLS = GRID_W * GRID_H;
  localparam int IDX_W = $clog2(CELLS);
  localparam int CNT_W = $clog2(NUM_MINES + 1);

  gen_state_t       state;
  logic [CNT_W-1:0] count;
  logic [IDX_W-1:0] cand;
  logic             cand_ok;
  logic             last_mine;
  logic             rd_in_range;
  logic [IDX_W-1:0] rd_idx;

  lfsr16 #(.OUT_W(IDX_W)) u_lfsr (
    .clk      (clk),
    .reset_in (reset_in),
    .seed     (SEED),
    .q        (cand)
  );

  // Candidates beyond the board (non power-of-two CELLS) or already mined are retried.
  assign cand_ok   = (int'(cand) < CELLS) && !mine_map[cand];
  assign last_mine = (int'(count) == NUM_MINES - 1);

  always_ff @(posedge clk) begin
    if (reset_in) begin
      state    <= ST_IDLE;
      mine_map <= '0;
      count    <= '0;
      busy     <= 1'b0;
      gen_done <= 1'b0;
    end else begin
      gen_done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (enable_mine_generation) begin
            state <= ST_CLEAR;
            busy  <= 1'b1;
          end
        end
        ST_CLEAR: begin
          mine_map <= '0;
          count    <= '0;
          state    <= ST_PICK;
        end
        ST_PICK: begin
          if (cand_ok) begin
            mine_map[cand] <= 1'b1;
            count          <= count + CNT_W'(1);
            // gen_done/busy are registered so they line up with the DONE cycle.
            if (last_mine) begin
              state    <= ST_DONE;
              busy     <= 1'b0;
              gen_done <= 1'b1;
            end
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Off-board neighbours are skipped, so corners top out at 3 and edges at 5.
  function automatic logic [3:0] adj_count(input logic [CELLS-1:0] map,
                                           input int x, input int y);
    logic [3:0] n;
    int         nx;
    int         ny;
    n = '0;
    for (int dy = -1; dy <= 1; dy++) begin
      for (int dx = -1; dx <= 1; dx++) begin
        nx = x + dx;
        ny = y + dy;
        if (!(dx == 0 && dy == 0) && nx >= 0 && nx < GRID_W && ny >= 0 && ny < GRID_H)
          n = n + 4'(map[IDX_W'(ny * GRID_W + nx)]);
      end
    end
    return n;
  endfunction

  assign rd_in_range = (int'(rd_x) < GRID_W) && (int'(rd_y) < GRID_H);
  assign rd_idx      = IDX_W'(int'(rd_y) * GRID_W + int'(rd_x));

  always_ff @(posedge clk) begin
    if (reset_in) begin
      rd_mine <= 1'b0;
      rd_adj  <= '0;
    end else if (rd_in_range) begin
      rd_mine <= mine_map[rd_idx];
      rd_adj  <= adj_count(mine_map, int'(rd_x), int'(rd_y));
    end else begin
      rd_mine <= 1'b0;
      rd_adj  <= '0;
    end
  end

endmodule

// File: tb/tb_mine_field_generator.sv
// Directed bench: 8x8/10 default board, 2x2/3 small board, 5x6/4 board for off-board reads.
// Latency: n/a.
// Backpressure: n/a.
module tb_mine_field_generator;

  logic        clk = 1'b0;
  logic        reset_in;
  logic [2:0]  start;
  logic [2:0]  busy_v;
  logic [2:0]  gd_v;

  logic        busy_a, gd_a, rm_a;
  logic [63:0] map_a;
  logic [2:0]  rx_a, ry_a;
  logic [3:0]  ra_a;

  logic        busy_b, gd_b, rm_b;
  logic [3:0]  map_b;
  logic [0:0]  rx_b, ry_b;
  logic [3:0]  ra_b;

  logic        busy_c, gd_c, rm_c;
  logic [29:0] map_c;
  logic [2:0]  rx_c, ry_c;
  logic [3:0]  ra_c;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  assign busy_v = {busy_c, busy_b, busy_a};
  assign gd_v   = {gd_c, gd_b, gd_a};

  mine_field_generator u_dut_a (
    .clk(clk), .reset_in(reset_in), .enable_mine_generation(start[0]),
    .busy(busy_a), .gen_done(gd_a), .mine_map(map_a),
    .rd_x(rx_a), .rd_y(ry_a), .rd_mine(rm_a), .rd_adj(ra_a)
  );

  mine_field_generator #(.GRID_W(2), .GRID_H(2), .NUM_MINES(3)) u_dut_b (
    .clk(clk), .reset_in(reset_in), .enable_mine_generation(start[1]),
    .busy(busy_b), .gen_done(gd_b), .mine_map(map_b),
    .rd_x(rx_b), .rd_y(ry_b), .rd_mine(rm_b), .rd_adj(ra_b)
  );

  mine_field_generator #(.GRID_W(5), .GRID_H(6), .NUM_MINES(4), .SEED(16'h1234)) u_dut_c (
    .clk(clk), .reset_in(reset_in), .enable_mine_generation(start[2]),
    .busy(busy_c), .gen_done(gd_c), .mine_map(map_c),
    .rd_x(rx_c), .rd_y(ry_c), .rd_mine(rm_c), .rd_adj(ra_c)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference neighbour count; coordinates off the w x h board read as 0.
  function automatic int adj_ref(input logic [63:0] m, input int w, input int h,
                                 input int x, input int y);
    int c;
    c = 0;
    if (x >= w || y >= h) return 0;
    for (int yy = y - 1; yy <= y + 1; yy++)
      for (int xx = x - 1; xx <= x + 1; xx++)
        if (!(xx == x && yy == y) && xx >= 0 && xx < w && yy >= 0 && yy < h)
          c += int'(m[6'(yy * w + xx)]);
    return c;
  endfunction

  // One generation on DUT d: checks busy rise, busy low at gen_done, a single
  // gen_done pulse, and that a start issued during DONE is dropped.
  task automatic gen(input int d, input int max_cyc, input bit poke, output int lat);
    int pulses;
    bit seen;
    seen = 1'b0;
    lat  = 0;
    start[d] = 1'b1;
    tick();
    start[d] = 1'b0;
    chk($sformatf("busy_rise_%0d", d), 64'(busy_v[d]), 64'd1);
    for (int n = 1; n <= max_cyc && !seen; n++) begin
      start[d] = (poke && n == 4);
      tick();
      if (gd_v[d]) begin
        seen = 1'b1;
        lat  = n + 1;
        chk($sformatf("busy_at_done_%0d", d), 64'(busy_v[d]), 64'd0);
      end
    end
    chk($sformatf("gen_done_seen_%0d", d), 64'(seen), 64'd1);
    pulses = seen ? 1 : 0;
    start[d] = 1'b1;
    tick();
    start[d] = 1'b0;
    chk($sformatf("done_start_ignored_%0d", d), 64'(busy_v[d]), 64'd0);
    for (int n = 0; n < 6; n++) begin
      if (gd_v[d]) pulses++;
      tick();
    end
    chk($sformatf("one_pulse_%0d", d), 64'(pulses), 64'd1);
  endtask

  initial begin
    int          lat;
    logic [63:0] snap, m1, m2;
    logic        busy_seen, gd_seen;

    reset_in = 1'b1;
    start    = 3'b000;
    rx_a = '0; ry_a = '0; rx_b = '0; ry_b = '0; rx_c = '0; ry_c = '0;

    // Reset, then idle reads return zero everywhere.
    tick();
    tick();
    reset_in = 1'b0;
    chk("rst_busy", 64'(busy_a), 64'd0);
    chk("rst_gen_done", 64'(gd_a), 64'd0);
    chk("rst_map", map_a, 64'd0);
    chk("rst_rd_mine", 64'(rm_a), 64'd0);
    chk("rst_rd_adj", 64'(ra_a), 64'd0);
    for (int i = 0; i < 10; i++) begin
      rx_a = 3'(i);
      ry_a = 3'(7 - (i % 8));
      tick();
      chk($sformatf("idle_adj_%0d", i), 64'(ra_a), 64'd0);
      chk($sformatf("idle_map_%0d", i), map_a, 64'd0);
      chk($sformatf("idle_busy_%0d", i), 64'(busy_a), 64'd0);
    end

    // First generation with a start poked 3 cycles into PICK.
    gen(0, 64 * 64, 1'b1, lat);
    chk("lat_min", 64'(lat >= 12), 64'd1);
    chk("lat_max", 64'(lat < 4096), 64'd1);
    chk("popcount_a1", 64'($countones(map_a)), 64'd10);
    snap = map_a;
    for (int i = 0; i < 20; i++) tick();
    chk("map_stable", map_a, snap);

    // Full read sweep over the 8x8 board, incl. corner (0,0) and edge (7,3).
    for (int y = 0; y < 8; y++) begin
      for (int x = 0; x < 8; x++) begin
        rx_a = 3'(x);
        ry_a = 3'(y);
        tick();
        chk($sformatf("adj_a_%0d_%0d", x, y), 64'(ra_a), 64'(adj_ref(snap, 8, 8, x, y)));
        chk($sformatf("mine_a_%0d_%0d", x, y), 64'(rm_a), 64'(snap[6'(y * 8 + x)]));
      end
    end

    // Reset four cycles after start: back to idle, cleared, no gen_done.
    start[0] = 1'b1;
    tick();
    start[0] = 1'b0;
    tick();
    tick();
    tick();
    reset_in = 1'b1;
    tick();
    reset_in = 1'b0;
    chk("midrst_busy", 64'(busy_a), 64'd0);
    chk("midrst_map", map_a, 64'd0);
    chk("midrst_gd", 64'(gd_a), 64'd0);
    busy_seen = 1'b0;
    gd_seen   = 1'b0;
    for (int i = 0; i < 30; i++) begin
      tick();
      busy_seen |= busy_a;
      gd_seen   |= gd_a;
    end
    chk("midrst_no_gd", 64'(gd_seen), 64'd0);
    chk("midrst_no_busy", 64'(busy_seen), 64'd0);
    gen(0, 64 * 64, 1'b0, lat);
    chk("popcount_after_rst", 64'($countones(map_a)), 64'd10);

    // Regeneration after different idle gaps.
    for (int i = 0; i < 5; i++) tick();
    gen(0, 64 * 64, 1'b0, lat);
    m1 = map_a;
    chk("popcount_regen1", 64'($countones(m1)), 64'd10);
    for (int i = 0; i < 17; i++) tick();
    gen(0, 64 * 64, 1'b0, lat);
    m2 = map_a;
    chk("popcount_regen2", 64'($countones(m2)), 64'd10);
    chk("regen_maps_differ", 64'(m1 != m2), 64'd1);

    // 2x2 board with 3 mines: empty cell sees 3, mined cells see 2.
    gen(1, 64 * 4, 1'b0, lat);
    chk("popcount_b", 64'($countones(map_b)), 64'd3);
    for (int y = 0; y < 2; y++) begin
      for (int x = 0; x < 2; x++) begin
        rx_b = 1'(x);
        ry_b = 1'(y);
        tick();
        chk($sformatf("adj_b_%0d_%0d", x, y), 64'(ra_b),
            map_b[2'(y * 2 + x)] ? 64'd2 : 64'd3);
        chk($sformatf("mine_b_%0d_%0d", x, y), 64'(rm_b), 64'(map_b[2'(y * 2 + x)]));
      end
    end

    // 5x6 board: whole 3-bit address space, off-board coordinates must read 0/0.
    gen(2, 64 * 30, 1'b0, lat);
    chk("popcount_c", 64'($countones(map_c)), 64'd4);
    snap = 64'(map_c);
    for (int y = 0; y < 8; y++) begin
      for (int x = 0; x < 8; x++) begin
        rx_c = 3'(x);
        ry_c = 3'(y);
        tick();
        chk($sformatf("adj_c_%0d_%0d", x, y), 64'(ra_c), 64'(adj_ref(snap, 5, 6, x, y)));
        chk($sformatf("mine_c_%0d_%0d", x, y), 64'(rm_c),
            (x < 5 && y < 6) ? 64'(snap[6'(y * 5 + x)]) : 64'd0);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
